// File: rtl/gba_gpu_pkg.sv
// Shared definitions for the GBA affine background sequencer: FSM encoding,
// reference-point widths and the sign-extending accumulate used per line.
package gba_gpu_pkg;

  localparam int REF_W = 28;
  localparam int D_W   = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG    = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_ADVANCE = 3'd4;

  // 20.8 reference plus sign-extended 8.8 increment, wrapping modulo 2^REF_W.
  function automatic logic signed [REF_W-1:0] sext_add(
    input logic signed [REF_W-1:0] base,
    input logic signed [D_W-1:0]   delta
  );
    logic signed [REF_W-1:0] ext;
    ext = {{(REF_W-D_W){delta[D_W-1]}}, delta};
    return base + ext;
  endfunction

endpackage

// File: rtl/gba_refpoint_axis.sv
// One axis (X or Y) of the affine reference point: CPU-visible copy, running
// reference, mosaic-held reference and a deferred-write pending flag.
module gba_refpoint_axis #(
  parameter int REF_W = gba_gpu_pkg::REF_W,
  parameter int D_W   = gba_gpu_pkg::D_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic signed [REF_W-1:0] wdata,
  input  logic                    wr_defer,
  input  logic                    reload,
  input  logic                    advance,
  input  logic                    mosaic_take,
  input  logic signed [D_W-1:0]   delta,
  output logic signed [REF_W-1:0] ref_pt,
  output logic signed [REF_W-1:0] ref_mosaic
);
  import gba_gpu_pkg::*;

  logic signed [REF_W-1:0] bg_reg;
  logic signed [REF_W-1:0] next_ref;
  logic                    pending;

  // A deferred CPU write replaces the increment for this line.
  always_comb begin
    next_ref = pending ? bg_reg : sext_add(ref_pt, delta);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bg_reg     <= '0;
      ref_pt     <= '0;
      ref_mosaic <= '0;
      pending    <= 1'b0;
    end else begin
      if (wr_en)
        bg_reg <= wdata;

      if (wr_en && !wr_defer) begin
        ref_pt     <= wdata;
        ref_mosaic <= wdata;
      end else if (reload) begin
        ref_pt     <= bg_reg;
        ref_mosaic <= bg_reg;
      end else if (advance) begin
        ref_pt <= next_ref;
        if (mosaic_take || pending)
          ref_mosaic <= next_ref;
      end

      if (reload)
        pending <= 1'b0;
      else if (wr_en && wr_defer)
        pending <= 1'b1;
      else if (advance)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/gba_affine_refpoint.sv
// Affine/bitmap BG reference-point sequencer: per-line drawer handshake FSM,
// vertical mosaic counter and two axis instances.
// Optional build macro: GBA_REFPOINT_WRITE_DEFER_EN defers CPU ref loads to ADVANCE.
module gba_affine_refpoint #(
  parameter int REF_W      = gba_gpu_pkg::REF_W,
  parameter int D_W        = gba_gpu_pkg::D_W,
  parameter int BUSY_GRACE = 2
) (
  input  logic                    fclk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    vblank_start,
  input  logic                    line_start,
  input  logic                    ref_x_we,
  input  logic                    ref_y_we,
  input  logic signed [REF_W-1:0] ref_x_wdata,
  input  logic signed [REF_W-1:0] ref_y_wdata,
  input  logic signed [D_W-1:0]   dmx,
  input  logic signed [D_W-1:0]   dmy,
  input  logic                    mosaic,
  input  logic [3:0]              Mosaic_V_Size,
  input  logic                    drawer_busy,
  output logic signed [REF_W-1:0] refX,
  output logic signed [REF_W-1:0] refY,
  output logic signed [REF_W-1:0] refX_mosaic,
  output logic signed [REF_W-1:0] refY_mosaic,
  output logic                    line_trigger,
  output logic                    drawline,
  output logic                    line_done,
  output logic                    line_overrun
);
  import gba_gpu_pkg::*;

  localparam int GRACE_W = (BUSY_GRACE < 1) ? 1 : $clog2(BUSY_GRACE + 1);

  logic [2:0]         state;
  logic [GRACE_W-1:0] grace;
  logic [3:0]         mosaic_vcnt;
  logic               advance;
  logic               mosaic_take;
  logic               wr_defer;

  assign line_trigger = (state == ST_TRIG);
  assign drawline     = (state == ST_START);
  assign line_done    = (state == ST_ADVANCE);
  assign advance      = (state == ST_ADVANCE) && !vblank_start;
  assign mosaic_take  = !mosaic || (mosaic_vcnt >= Mosaic_V_Size);

`ifdef GBA_REFPOINT_WRITE_DEFER_EN
  // The drawer holds its own copy from line_trigger until the line finishes.
  assign wr_defer = ((state == ST_TRIG) || (state == ST_START) || (state == ST_WAIT))
                    && !vblank_start;
`else
  assign wr_defer = 1'b0;
`endif

  always_ff @(posedge fclk) begin
    if (reset) begin
      state        <= ST_IDLE;
      grace        <= '0;
      mosaic_vcnt  <= '0;
      line_overrun <= 1'b0;
    end else if (vblank_start) begin
      state        <= ST_IDLE;
      mosaic_vcnt  <= '0;
      line_overrun <= 1'b0;
    end else begin
      if (line_start && (state != ST_IDLE))
        line_overrun <= 1'b1;

      case (state)
        ST_IDLE:  if (line_start && enable) state <= ST_TRIG;
        ST_TRIG:  state <= ST_START;
        ST_START: begin
          grace <= GRACE_W'(BUSY_GRACE);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (grace != '0)
            grace <= grace - 1'b1;
          else if (!drawer_busy)
            state <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          mosaic_vcnt <= mosaic_take ? 4'd0 : mosaic_vcnt + 4'd1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  gba_refpoint_axis #(.REF_W(REF_W), .D_W(D_W)) u_axis_x (
    .clk         (fclk),
    .reset       (reset),
    .wr_en       (ref_x_we),
    .wdata       (ref_x_wdata),
    .wr_defer    (wr_defer),
    .reload      (vblank_start),
    .advance     (advance),
    .mosaic_take (mosaic_take),
    .delta       (dmx),
    .ref_pt      (refX),
    .ref_mosaic  (refX_mosaic)
  );

  gba_refpoint_axis #(.REF_W(REF_W), .D_W(D_W)) u_axis_y (
    .clk         (fclk),
    .reset       (reset),
    .wr_en       (ref_y_we),
    .wdata       (ref_y_wdata),
    .wr_defer    (wr_defer),
    .reload      (vblank_start),
    .advance     (advance),
    .mosaic_take (mosaic_take),
    .delta       (dmy),
    .ref_pt      (refY),
    .ref_mosaic  (refY_mosaic)
  );

endmodule
